cg_rr_arbiter: RTL and testbench
================================

# cg_rr_arbiter

Round-robin arbiter that shares one resource among `N_REQ` requesters. It selects with a rotating-priority search built on the `cg_priority_encoder` function, then holds the grant until the owner releases, drops its request, or exceeds a hold limit. Place it in front of any shared port, such as a memory port, bus master slot or shared functional unit. All grant outputs are registered so downstream muxes see glitch-free selects.

## Interface
- `N_REQ`, 4: number of requesters; legal range is 2 or more.
- `MAX_HOLD`, 0: maximum cycles one owner may keep the grant. 0 disables the limit.
- `IDX_W`, `$clog2(N_REQ)`: width of the grant index. This is derived and must not be overridden.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst_n` input 1: reset; asynchronous, active-low.
- `i_req` input `N_REQ`: per-requester request level. It must stay high for as long as the requester wants the grant.
- `i_release` input 1: the current owner finishes this cycle. It is ignored when `o_busy`=0.
- `o_gnt` output `N_REQ`: one-hot grant, or all zeros.
- `o_gnt_index` output `IDX_W`: binary index of the owner. It is 0 when `o_busy`=0.
- `o_busy` output 1: a grant is active; equals `|o_gnt`.

## Operation
- **State:**
  - FSM with IDLE (no owner) and BUSY (owner held).
  - Rotation pointer `ptr` (`IDX_W` bits): the highest-priority index for the next arbitration.
  - Hold counter `hold_cnt` (`$clog2(MAX_HOLD+1)` bits; 1 bit when `MAX_HOLD`=0).
- **Arbitration function:**
  - The winner is the first set bit of `i_req` scanning `ptr`, `ptr+1`, …, `N_REQ-1`, 0, …, `ptr-1` (mod `N_REQ`).
  - Implement it as a masked priority-encode (`i_req` & mask(≥`ptr`)), falling back to an unmasked encode when the masked vector is zero.
  - `i_req`=0 means no winner.
- **IDLE:**
  - If a winner exists: go to BUSY, set the owner to the winner, set `hold_cnt`=1, and set `ptr`=(winner+1) mod `N_REQ`.
  - Otherwise stay in IDLE.
- **BUSY release condition** is any one of:
  - `i_req[owner]`=0;
  - `i_release`=1;
  - `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD`.
- **BUSY, release true:**
  - Arbitrate immediately on the current `i_req` using the already-advanced `ptr`.
  - The previous owner is therefore lowest priority and wins only if it is the sole requester.
  - A winner gives a back-to-back grant: new owner, `hold_cnt`=1, `ptr` advanced.
  - No winner returns the FSM to IDLE.
- **BUSY, release false:**
  - Keep the owner.
  - `hold_cnt` increments, saturating at `MAX_HOLD`. With `MAX_HOLD`=0 it stays at 1.
- **Edge cases:**
  - Non-owner request changes never preempt the owner.
  - Simultaneous `i_release` and owner request drop count as a single release.
  - `N_REQ` not a power of 2: the `ptr` increment must wrap explicitly at `N_REQ-1`→0, not by overflow.
- **Reset values** (any time, including mid-grant): state IDLE, `ptr`=0, `hold_cnt`=0, `o_gnt`=0, `o_gnt_index`=0, `o_busy`=0. The grant is dropped asynchronously on reset assertion.

## Timing
- **Outputs:** all registered, with no combinational path from `i_req` or `i_release` to any output.
- **Grant latency:** a request sampled high at edge k in IDLE gives `o_gnt` high after edge k. The owner sees its grant in the cycle after it raises `i_req`.
- **Release latency:** a release seen at edge k changes `o_gnt` after edge k. It either hands over directly (no idle cycle) or drops to 0.
- **Minimum tenure:** 1 cycle. A grant-plus-release sequence therefore sustains one handover per cycle.
- **Hold limit:** the owner keeps the grant for exactly `MAX_HOLD` cycles when it does not release earlier.
- **Requester responsibility:** use the resource only while its own `o_gnt` bit is high. Deassert `i_req` or pulse `i_release` in the last cycle of use.

## Test plan
All scenarios use `N_REQ`=4 unless noted.
- **Reset:** hold `i_rst_n`=0 with `i_req`=4'b1111 → `o_gnt`=0, `o_busy`=0, `o_gnt_index`=0. On the first edge after release: `o_gnt`=4'b0001.
- **Fair rotation:** `i_req`=4'b1111 and `i_release`=1 every cycle → `o_gnt_index` sequence 0,1,2,3,0,1 with no idle cycles.
- **Wrap and skip:** `ptr`=3 (after owner 2) and `i_req`=4'b0011 → grant 0 next, then 1, then 0.
- **Hold limit:** `MAX_HOLD`=4, `i_req`=4'b0011 held and `i_release`=0 → owner 0 for 4 cycles, owner 1 for 4 cycles, then owner 0 again. With `i_req`=4'b0001 only, owner 0 is re-granted with no gap.
- **Owner drop:** owner 2 with `i_req` 4'b0100→4'b0000 → `o_busy`=0 next cycle. A later `i_req`=4'b0101 grants 0 first (`ptr`=3 wraps past 3 to 0).
- **Reset mid-grant:** assert `i_rst_n`=0 while owner 1 → `o_gnt`=0 immediately (asynchronous). After deassertion with `i_req`=4'b1110 → grant 1 (`ptr` reset to 0).

Source files
------------

// File: rtl/cg_rr_arbiter.sv
// cg_rr_arbiter: round-robin arbiter with grant hold.
// A winner is picked with a rotating-priority search (masked priority encode
// with unmasked fallback). The owner keeps the grant until it releases, drops
// its request, or reaches MAX_HOLD cycles of tenure. All outputs are registered.
//
// Handshake: i_req[k] is a level held high while requester k wants the
// resource; the grant o_gnt[k] appears the cycle after the request is first
// sampled, and the owner ends its tenure by dropping i_req[k] or pulsing
// i_release in its last cycle of use. i_release is ignored while idle.
module cg_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_index,
  output logic             o_busy,
  output logic             o_state
);

  localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  masked_req;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;
  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  nxt_ptr;
  logic              hold_hit;
  logic              rel_cond;

  // Lowest set bit of vec wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] cg_priority_encoder(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign o_state = state;

  // Rotating-priority winner search and release decision for the current cycle.
  always_comb begin
    mask       = '0;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (IDX_W'(i) >= ptr);
    end
    masked_req = i_req & mask;
    win_valid  = |i_req;
    if (|masked_req) win_idx = cg_priority_encoder(masked_req);
    else             win_idx = cg_priority_encoder(i_req);
    win_onehot[win_idx] = 1'b1;
    // Explicit wrap so non-power-of-2 N_REQ never lands on an unused index.
    nxt_ptr  = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
    hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
    rel_cond = !i_req[o_gnt_index] || i_release || hold_hit;
  end

  // Single-process FSM: owner, rotation pointer, tenure counter and outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      o_gnt       <= '0;
      o_gnt_index <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state       <= BUSY;
            o_gnt       <= win_onehot;
            o_gnt_index <= win_idx;
            o_busy      <= 1'b1;
            hold_cnt    <= HOLD_ONE;
            ptr         <= nxt_ptr;
          end
        end
        BUSY: begin
          if (rel_cond) begin
            if (win_valid) begin
              // Back-to-back handover; ptr already points past the old owner.
              o_gnt       <= win_onehot;
              o_gnt_index <= win_idx;
              o_busy      <= 1'b1;
              hold_cnt    <= HOLD_ONE;
              ptr         <= nxt_ptr;
            end else begin
              state       <= IDLE;
              o_gnt       <= '0;
              o_gnt_index <= '0;
              o_busy      <= 1'b0;
              hold_cnt    <= '0;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: begin
          state       <= IDLE;
          o_gnt       <= '0;
          o_gnt_index <= '0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the registered grant outputs.
  a_gnt_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_gnt));
  a_busy_match: assert property (@(posedge i_clk) disable iff (!i_rst_n) o_busy == (|o_gnt));

endmodule

// File: tb/tb_cg_rr_arbiter.sv
// Bench for cg_rr_arbiter: three instances (N=4 unlimited hold, N=4 hold 4,
// N=3 unlimited hold) driven by the same directed vectors, checked every cycle
// against a scan-order reference model and at key points against literals.
module tb_cg_rr_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;

  logic [3:0] a_gnt, b_gnt;
  logic [2:0] c_gnt;
  logic [1:0] a_idx, b_idx, c_idx;
  logic       a_busy, b_busy, c_busy;
  logic       a_st, b_st, c_st;

  cg_rr_arbiter #(.N_REQ(4), .MAX_HOLD(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_release(rel),
    .o_gnt(a_gnt), .o_gnt_index(a_idx), .o_busy(a_busy), .o_state(a_st));

  cg_rr_arbiter #(.N_REQ(4), .MAX_HOLD(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_release(rel),
    .o_gnt(b_gnt), .o_gnt_index(b_idx), .o_busy(b_busy), .o_state(b_st));

  cg_rr_arbiter #(.N_REQ(3), .MAX_HOLD(0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[2:0]), .i_release(rel),
    .o_gnt(c_gnt), .o_gnt_index(c_idx), .o_busy(c_busy), .o_state(c_st));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner/pointer/tenure bookkeeping; the winner is found by literally walking
  // ptr, ptr+1, ... modulo n.
  typedef struct {
    bit busy;
    int owner;
    int ptr;
    int cnt;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0};
  mdl_t mb = '{0, 0, 0, 0};
  mdl_t mc = '{0, 0, 0, 0};

  function automatic mdl_t mdl_step(input mdl_t s, input int n, input int mh,
                                    input logic [3:0] r, input logic rl);
    mdl_t t;
    bit   found;
    t = s;
    if (s.busy && r[s.owner] && !rl && !(mh != 0 && s.cnt == mh)) begin
      if (mh != 0 && t.cnt < mh) t.cnt = t.cnt + 1;
    end else begin
      found   = 0;
      t.busy  = 0;
      t.owner = 0;
      for (int k = 0; k < n; k++) begin
        int w;
        w = (s.ptr + k) % n;
        if (!found && r[w]) begin
          found   = 1;
          t.busy  = 1;
          t.owner = w;
          t.cnt   = 1;
          t.ptr   = (w + 1) % n;
        end
      end
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = '{0, 0, 0, 0};
      mb = '{0, 0, 0, 0};
      mc = '{0, 0, 0, 0};
    end else begin
      ma = mdl_step(ma, 4, 0, req, rel);
      mb = mdl_step(mb, 4, 4, req, rel);
      mc = mdl_step(mc, 3, 0, {1'b0, req[2:0]}, rel);
    end
  end

  function automatic logic [31:0] exp_gnt(input mdl_t m);
    return m.busy ? (32'd1 << m.owner) : 32'd0;
  endfunction

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("a_gnt",  32'(a_gnt),  exp_gnt(ma));
    check("a_idx",  32'(a_idx),  32'(ma.owner));
    check("a_busy", 32'(a_busy), 32'(ma.busy));
    check("b_gnt",  32'(b_gnt),  exp_gnt(mb));
    check("b_idx",  32'(b_idx),  32'(mb.owner));
    check("b_busy", 32'(b_busy), 32'(mb.busy));
    check("c_gnt",  32'(c_gnt),  exp_gnt(mc));
    check("c_idx",  32'(c_idx),  32'(mc.owner));
    check("c_busy", 32'(c_busy), 32'(mc.busy));
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] r, input logic rl);
    req = r;
    rel = rl;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  int exp_a6[6] = '{0, 1, 2, 3, 0, 1};
  int exp_c6[6] = '{0, 1, 2, 0, 1, 2};
  int exp_b12[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    // Reset held with every requester asking.
    req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt",  32'(a_gnt),  32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_idx",  32'(a_idx),  32'd0);
    rst_n = 1'b1;

    // Fair rotation: release every cycle, all requesting.
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 1'b1);
      check("rot_a_idx",  32'(a_idx), 32'(exp_a6[i]));
      check("rot_c_idx",  32'(c_idx), 32'(exp_c6[i]));
      check("rot_a_busy", 32'(a_busy), 32'd1);
    end
    check("rot_first_gnt_c", 32'(c_gnt), 32'b100);

    // Wrap and skip: owner 2 leaves ptr at 3, then only 0 and 1 request.
    cycle(4'b1111, 1'b1);
    check("wrap_own2", 32'(a_idx), 32'd2);
    cycle(4'b0011, 1'b1);
    check("wrap_gnt0", 32'(a_gnt), 32'b0001);
    cycle(4'b0011, 1'b1);
    check("wrap_gnt1", 32'(a_gnt), 32'b0010);
    cycle(4'b0011, 1'b1);
    check("wrap_gnt0b", 32'(a_gnt), 32'b0001);

    // Owner drop: owner 0 drops -> idle; then owner 2 drops -> idle.
    cycle(4'b0000, 1'b0);
    check("drop_idle0", 32'(a_busy), 32'd0);
    cycle(4'b0100, 1'b0);
    check("drop_own2", 32'(a_idx), 32'd2);
    cycle(4'b0100, 1'b0);
    check("drop_hold2", 32'(a_gnt), 32'b0100);
    cycle(4'b0000, 1'b0);
    check("drop_busy", 32'(a_busy), 32'd0);
    check("drop_idx",  32'(a_idx),  32'd0);
    cycle(4'b0101, 1'b0);
    check("drop_ptr_wrap", 32'(a_gnt), 32'b0001);
    cycle(4'b0101, 1'b1);
    check("drop_next2", 32'(a_idx), 32'd2);
    cycle(4'b0000, 1'b0);

    // Hold limit on dut_b (4 cycles); dut_a keeps owner 0 indefinitely.
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0011, 1'b0);
      check("hold_b_idx", 32'(b_idx), 32'(exp_b12[i]));
      check("hold_a_idx", 32'(a_idx), 32'd0);
    end
    // Sole requester at the limit is re-granted with no gap.
    for (int i = 0; i < 6; i++) begin
      cycle(4'b0001, 1'b0);
      check("solo_b_busy", 32'(b_busy), 32'd1);
      check("solo_b_gnt",  32'(b_gnt),  32'b0001);
    end

    // Reset mid-grant: grant dropped asynchronously, ptr back to 0.
    cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b0);
    check("mid_own1", 32'(a_gnt), 32'b0010);
    rst_n = 1'b0;
    #1;
    check("mid_async_gnt",  32'(a_gnt),  32'd0);
    check("mid_async_busy", 32'(a_busy), 32'd0);
    check("mid_async_idx",  32'(a_idx),  32'd0);
    cycle(4'b1110, 1'b0);
    cycle(4'b1110, 1'b0);
    check("mid_held_gnt", 32'(b_gnt), 32'd0);
    rst_n = 1'b1;
    cycle(4'b1110, 1'b0);
    check("mid_after_a", 32'(a_gnt), 32'b0010);
    check("mid_after_c", 32'(c_gnt), 32'b010);
    cycle(4'b1110, 1'b1);
    check("mid_next_a", 32'(a_idx), 32'd2);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
